sva_stim_gen: RTL



---
 rtl/sva_stim_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/sva_stim_gen.sv
// sva_stim_gen: synthesises gclk/grst from sys_clk, plays a stored bit pattern on b
// and counts rising edges of the checker's succ/fail/lazy_succ verdicts.
module sva_stim_gen #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int HALF_W    = 8,
    parameter int RST_CYC   = 2,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pat_wr_en,
    input  logic [ADDR_W-1:0] pat_wr_addr,
    input  logic              pat_wr_data,
    input  logic [ADDR_W:0]   pat_len,
    input  logic [HALF_W-1:0] half_period,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              gclk,
    output logic              grst,
    output logic              b,
    input  logic              succ,
    input  logic              fail,
    input  logic              lazy_succ,
    output logic [CNT_W-1:0]  succ_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  lazy_cnt
);
    typedef enum logic [1:0] {IDLE, RESET, RUN, DRAIN} state_t;
    state_t state_q, state_d;
    logic mem [DEPTH];
    logic [HALF_W-1:0] hp_q, hc_q;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0] pc_q;
    logic gclk_q, b_q, done_q;
    logic [2:0] v_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic go, tick, fall, last_rst, last_run, last_drn;
    logic [2:0] v_i;
    assign v_i      = {lazy_succ, fail, succ};
    assign go       = state_q == IDLE && start;
    assign tick     = state_q != IDLE && hc_q == hp_q - HALF_W'(1);
    // A falling gclk edge closes one gclk period; all sequencing keys off it.
    assign fall     = tick && gclk_q;
    assign last_rst = fall && pc_q == 8'(RST_CYC - 1);
    assign last_run = fall && {1'b0, idx_q} == len_q - (ADDR_W+1)'(1);
    assign last_drn = fall && pc_q == 8'(DRAIN_CYC - 1);

    always_ff @(posedge sys_clk) begin
        if (pat_wr_en && state_q == IDLE) mem[pat_wr_addr] <= pat_wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            hp_q    <= HALF_W'(1);
            hc_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            pc_q    <= '0;
            gclk_q  <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            v_q     <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= state_q == DRAIN && last_drn;
            hc_q    <= (state_q == IDLE || tick) ? '0 : hc_q + HALF_W'(1);
            gclk_q  <= state_q != IDLE && (gclk_q ^ tick);
            v_q     <= v_i;
            if (go) begin
                hp_q  <= half_period == '0 ? HALF_W'(1) : half_period;
                len_q <= pat_len > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : pat_len;
                idx_q <= '0;
                pc_q  <= '0;
            end
            if (state_q == RESET && fall) begin
                pc_q <= last_rst ? 8'd0 : pc_q + 8'd1;
                if (last_rst) b_q <= len_q != '0 && mem[0];
            end
            if (state_q == RUN && fall) begin
                idx_q <= idx_q + ADDR_W'(1);
                b_q   <= !last_run && mem[idx_q + ADDR_W'(1)];
            end
            if (state_q == DRAIN && fall) pc_q <= pc_q + 8'd1;
            for (int i = 0; i < 3; i++)
                cnt_q[i] <= go ? '0 :
                            (state_q != IDLE && v_i[i] && !v_q[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) :
                            cnt_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RESET : IDLE;
            RESET:   if (last_rst) state_d = len_q == '0 ? DRAIN : RUN;
            RUN:     if (last_run) state_d = DRAIN;
            DRAIN:   if (last_drn) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = state_q != IDLE;
        grst     = state_q == RESET;
        gclk     = gclk_q;
        b        = b_q;
        done     = done_q;
        succ_cnt = cnt_q[0];
        fail_cnt = cnt_q[1];
        lazy_cnt = cnt_q[2];
    end
endmodule
